hdlverifier_capture_ctrl: RTL and testbench

Sequencing controller for the FPGA data-capture path. It arms on request and counts pre-trigger samples before accepting the registered trigger from the capture comparator. It then counts post-trigger samples and drives write addressing into an external circular capture RAM (depth 2**ADDR_WIDTH). After capture it streams the read addresses of the captured window, oldest first, to the readout logic through a valid/ready handshake.

---
 rtl/hdlverifier_capture_pkg.sv | 20 ++
 rtl/hdlverifier_capture_rd_seq.sv | 66 ++++++
 rtl/hdlverifier_capture_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hdlverifier_capture_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlverifier_capture_pkg.sv
// ---------------------------------------------------------------------------
// hdlverifier_capture_pkg
// Shared definitions for the capture sequencing controller: the controller
// state encoding and the default buffer geometry.
// Ports: none (package).
// ---------------------------------------------------------------------------
package hdlverifier_capture_pkg;

   localparam int CAP_ADDR_WIDTH = 10;
   localparam int DEPTH          = 2**CAP_ADDR_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PREFILL   = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_READ      = 3'd4
   } cap_state_t;

endpackage

// File: rtl/hdlverifier_capture_rd_seq.sv
// ---------------------------------------------------------------------------
// hdlverifier_capture_rd_seq
// Read-phase sequencer: on i_start loads i_base and streams DEPTH read
// addresses through a valid/ready handshake, oldest sample first.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_clear          drop the stream (abort); valid falls on the next edge
//   i_start          single-cycle start, loads i_base and clears the beat count
//   i_base           first read address of the window
//   i_rd_ready       consumer accepts the current address
//   o_rd_valid       address stream active
//   o_rd_addr        current read address
//   o_rd_last        current beat is the final one of the window
//   o_done           final beat accepted this cycle
// ---------------------------------------------------------------------------
module hdlverifier_capture_rd_seq #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_clear,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base,
   input  logic                  i_rd_ready,
   output logic                  o_rd_valid,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic                  o_rd_last,
   output logic                  o_done
);

   logic                  r_valid;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_beat;
   logic                  w_fire;
   logic                  w_last;

   assign w_fire = r_valid & i_rd_ready;
   // terminal beat is D-1, i.e. all ones
   assign w_last = r_valid & (r_beat == '1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_beat  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_start) begin
         r_valid <= 1'b1;
         r_addr  <= i_base;
         r_beat  <= '0;
      end else if (w_fire) begin
         r_addr <= r_addr + ADDR_WIDTH'(1);
         r_beat <= r_beat + ADDR_WIDTH'(1);
         if (w_last) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_rd_valid = r_valid;
   assign o_rd_addr  = r_addr;
   assign o_rd_last  = w_last;
   assign o_done     = w_fire & w_last;

endmodule

// File: rtl/hdlverifier_capture_ctrl.sv
// ---------------------------------------------------------------------------
// hdlverifier_capture_ctrl
// Capture sequencing controller: arm, pre-trigger fill, trigger wait,
// post-trigger fill into a circular RAM of depth 2**ADDR_WIDTH, then stream
// the captured window's read addresses, oldest first.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_clk_enable            sample-valid qualifier
//   i_arm, i_abort          start a capture (IDLE only) / return to IDLE
//   i_trigger               comparator match for the sample written this cycle
//   i_trigger_position      pre-trigger sample count P, taken on accepted arm
//   o_wr_en, o_wr_addr      RAM write strobe (combinational) and address
//   o_trig_addr             address of the trigger sample
//   o_busy                  not IDLE
//   o_capture_done          one-cycle pulse on entry to READ
//   o_rd_valid, o_rd_addr   read address stream
//   i_rd_ready, o_rd_last   stream handshake / final beat marker
//
// state     | meaning
// IDLE      | waiting for arm, no writes
// PREFILL   | writing the P pre-trigger samples, trigger ignored
// WAIT_TRIG | writing circularly until an enabled trigger
// POST      | writing the D-P-1 post-trigger samples
// READ      | streaming the D read addresses of the window
// ---------------------------------------------------------------------------
module hdlverifier_capture_ctrl
   import hdlverifier_capture_pkg::*;
#(
   parameter int ADDR_WIDTH = CAP_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_clk_enable,
   input  logic                  i_arm,
   input  logic                  i_abort,
   input  logic                  i_trigger,
   input  logic [ADDR_WIDTH-1:0] i_trigger_position,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [ADDR_WIDTH-1:0] o_trig_addr,
   output logic                  o_busy,
   output logic                  o_capture_done,
   output logic                  o_rd_valid,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   input  logic                  i_rd_ready,
   output logic                  o_rd_last
);

   cap_state_t            r_state;
   cap_state_t            w_next;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [ADDR_WIDTH-1:0] r_trig_addr;
   logic [ADDR_WIDTH-1:0] r_p;
   logic [ADDR_WIDTH-1:0] r_pre_cnt;
   logic [ADDR_WIDTH-1:0] r_post_cnt;
   logic                  r_busy;
   logic                  r_capture_done;

   logic                  w_wr_en;
   logic                  w_arm_ok;
   logic                  w_trig_ok;
   logic                  w_rd_start;
   logic                  w_rd_done;
   logic [ADDR_WIDTH-1:0] w_rd_base;
   logic [ADDR_WIDTH-1:0] w_post_len;
   logic [ADDR_WIDTH-1:0] w_pre_inc;
   logic [ADDR_WIDTH-1:0] w_post_inc;

   // D-P-1 mod D is simply the bitwise complement of P
   assign w_post_len = ~r_p;
   assign w_pre_inc  = r_pre_cnt + ADDR_WIDTH'(1);
   assign w_post_inc = r_post_cnt + ADDR_WIDTH'(1);

   assign w_wr_en = i_clk_enable &
                    ((r_state == ST_PREFILL) | (r_state == ST_WAIT_TRIG) | (r_state == ST_POST));

   always_comb begin
      w_next    = r_state;
      w_arm_ok  = 1'b0;
      w_trig_ok = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_arm) begin
               w_arm_ok = 1'b1;
               w_next   = (i_trigger_position == '0) ? ST_WAIT_TRIG : ST_PREFILL;
            end
         end
         ST_PREFILL: begin
            if (i_clk_enable && (w_pre_inc == r_p)) begin
               w_next = ST_WAIT_TRIG;
            end
         end
         ST_WAIT_TRIG: begin
            if (i_clk_enable && i_trigger) begin
               w_trig_ok = 1'b1;
               w_next    = (w_post_len != '0) ? ST_POST : ST_READ;
            end
         end
         ST_POST: begin
            if (i_clk_enable && (w_post_inc == w_post_len)) begin
               w_next = ST_READ;
            end
         end
         ST_READ: begin
            if (w_rd_done) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
      if (i_abort) begin
         w_next    = ST_IDLE;
         w_arm_ok  = 1'b0;
         w_trig_ok = 1'b0;
      end
   end

   assign w_rd_start = (w_next == ST_READ) && (r_state != ST_READ);

   // On a direct WAIT_TRIG -> READ hop the trigger address is still being
   // loaded, so take it from the live write address instead.
   assign w_rd_base = ((r_state == ST_WAIT_TRIG) ? r_wr_addr : r_trig_addr) - r_p;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= ST_IDLE;
         r_wr_addr      <= '0;
         r_trig_addr    <= '0;
         r_p            <= '0;
         r_pre_cnt      <= '0;
         r_post_cnt     <= '0;
         r_busy         <= 1'b0;
         r_capture_done <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_wr_en) begin
            r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
         end
         if (w_arm_ok) begin
            r_p       <= i_trigger_position;
            r_pre_cnt <= '0;
         end else if ((r_state == ST_PREFILL) && i_clk_enable) begin
            r_pre_cnt <= w_pre_inc;
         end
         if (w_trig_ok) begin
            r_trig_addr <= r_wr_addr;
            r_post_cnt  <= '0;
         end else if ((r_state == ST_POST) && i_clk_enable) begin
            r_post_cnt <= w_post_inc;
         end
         r_busy         <= (w_next != ST_IDLE);
         r_capture_done <= w_rd_start;
      end
   end

   hdlverifier_capture_rd_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rd_seq (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (i_abort),
      .i_start    (w_rd_start),
      .i_base     (w_rd_base),
      .i_rd_ready (i_rd_ready),
      .o_rd_valid (o_rd_valid),
      .o_rd_addr  (o_rd_addr),
      .o_rd_last  (o_rd_last),
      .o_done     (w_rd_done)
   );

   assign o_wr_en        = w_wr_en;
   assign o_wr_addr      = r_wr_addr;
   assign o_trig_addr    = r_trig_addr;
   assign o_busy         = r_busy;
   assign o_capture_done = r_capture_done;

endmodule

// File: tb/tb_hdlverifier_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hdlverifier_capture_ctrl
// Directed bench for the capture controller with a 16-entry buffer.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_hdlverifier_capture_ctrl;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          clk_enable;
   logic          arm;
   logic          abort;
   logic          trigger;
   logic [AW-1:0] trigger_position;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] trig_addr;
   logic          busy;
   logic          capture_done;
   logic          rd_valid;
   logic [AW-1:0] rd_addr;
   logic          rd_ready;
   logic          rd_last;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hdlverifier_capture_ctrl #(.ADDR_WIDTH(AW)) dut (
      .i_clk              (clk),
      .i_reset            (reset),
      .i_clk_enable       (clk_enable),
      .i_arm              (arm),
      .i_abort            (abort),
      .i_trigger          (trigger),
      .i_trigger_position (trigger_position),
      .o_wr_en            (wr_en),
      .o_wr_addr          (wr_addr),
      .o_trig_addr        (trig_addr),
      .o_busy             (busy),
      .o_capture_done     (capture_done),
      .o_rd_valid         (rd_valid),
      .o_rd_addr          (rd_addr),
      .i_rd_ready         (rd_ready),
      .o_rd_last          (rd_last)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Drains one READ window starting at base; toggle applies ready 1,0,0,1.
   task automatic read_window(input logic [AW-1:0] base, input bit toggle);
      logic [AW-1:0] exp_addr;
      int            beats;
      int            k;
      logic          rdy;
      exp_addr = base;
      beats    = 0;
      k        = 0;
      while (beats < 16 && k < 80) begin
         chk("rd_valid", rd_valid, 1);
         chk("rd_addr", rd_addr, exp_addr);
         chk("rd_last", rd_last, (beats == 15));
         chk("capture_done", capture_done, (k == 0));
         chk("wr_en_read", wr_en, 0);
         rdy = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
         rd_ready = rdy;
         step();
         if (rdy) begin
            beats++;
            exp_addr = exp_addr + 4'd1;
         end
         k++;
      end
      rd_ready = 1'b0;
      chk("beats", beats, 16);
      chk("rd_valid_end", rd_valid, 0);
      chk("busy_end", busy, 0);
   endtask

   initial begin
      reset            = 1'b1;
      clk_enable       = 1'b1;
      arm              = 1'b0;
      abort            = 1'b0;
      trigger          = 1'b0;
      trigger_position = '0;
      rd_ready         = 1'b0;
      steps(2);
      reset = 1'b0;

      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_trig_addr", trig_addr, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", capture_done, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_last", rd_last, 0);

      // P=4, trigger at wr_addr 9
      arm = 1'b1; trigger_position = 4'd4;
      step();
      arm = 1'b0;
      chk("t1_busy", busy, 1);
      chk("t1_wr_en", wr_en, 1);
      chk("t1_wr_start", wr_addr, 0);
      steps(4);
      chk("t1_after_prefill", wr_addr, 4);
      steps(5);
      chk("t1_wr_at_trig", wr_addr, 9);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      chk("t1_trig_addr", trig_addr, 9);
      chk("t1_wr_post", wr_addr, 10);
      steps(10);
      chk("t1_no_done_yet", capture_done, 0);
      step();
      chk("t1_wr_end", wr_addr, 5);
      read_window(4'd5, 1'b0);

      // P=0: park wr_addr at 2 via an abort in WAIT_TRIG
      reset = 1'b1;
      step();
      reset = 1'b0;
      arm = 1'b1; trigger_position = 4'd0;
      step();
      arm = 1'b0;
      chk("t2_direct_wait", wr_addr, 0);
      steps(2);
      clk_enable = 1'b0; abort = 1'b1;
      step();
      abort = 1'b0; clk_enable = 1'b1;
      chk("t2_abort_idle", busy, 0);
      chk("t2_wr_parked", wr_addr, 2);
      arm = 1'b1;
      step();
      arm = 1'b0;
      chk("t2_busy", busy, 1);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      chk("t2_trig_addr", trig_addr, 2);
      chk("t2_wr_post", wr_addr, 3);
      steps(15);
      chk("t2_wr_end", wr_addr, 2);
      read_window(4'd2, 1'b1);

      // P=15 with ignored triggers, then direct WAIT_TRIG -> READ
      arm = 1'b1; trigger_position = 4'd15;
      step();
      arm = 1'b0;
      for (int i = 0; i < 15; i++) begin
         trigger = (i == 3) || (i == 14);
         step();
      end
      trigger = 1'b0;
      chk("t3_trig_ignored", trig_addr, 2);
      chk("t3_wr_after_prefill", wr_addr, 1);
      chk("t3_busy", busy, 1);
      clk_enable = 1'b0; trigger = 1'b1;
      #1;
      chk("t3_wr_en_gated", wr_en, 0);
      step();
      chk("t3_trig_noenable", trig_addr, 2);
      chk("t3_wr_hold", wr_addr, 1);
      clk_enable = 1'b1; trigger = 1'b0;
      steps(6);
      chk("t3_wr_at_trig", wr_addr, 7);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      chk("t3_trig_addr", trig_addr, 7);
      chk("t3_wr_end", wr_addr, 8);
      read_window(4'd8, 1'b0);

      // abort mid-POST, re-arm on the following cycle
      arm = 1'b1; trigger_position = 4'd4;
      step();
      arm = 1'b0;
      steps(4);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      chk("t4_trig_addr", trig_addr, 12);
      steps(3);
      chk("t4_wr_mid_post", wr_addr, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t4_abort_busy", busy, 0);
      chk("t4_abort_wr_en", wr_en, 0);
      chk("t4_abort_done", capture_done, 0);
      chk("t4_abort_wr", wr_addr, 1);
      arm = 1'b1; trigger_position = 4'd2;
      step();
      arm = 1'b0;
      chk("t4_rearm_busy", busy, 1);
      steps(2);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      chk("t4_trig_addr2", trig_addr, 3);
      steps(13);
      chk("t4_done", capture_done, 1);
      chk("t4_rd_valid", rd_valid, 1);
      chk("t4_rd_base", rd_addr, 1);
      chk("t4_wr_end", wr_addr, 1);
      rd_ready = 1'b1;
      steps(3);
      rd_ready = 1'b0;
      chk("t4_rd_mid", rd_addr, 4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t4_rst_wr", wr_addr, 0);
      chk("t4_rst_trig", trig_addr, 0);
      chk("t4_rst_rd_addr", rd_addr, 0);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_valid", rd_valid, 0);
      chk("t4_rst_done", capture_done, 0);
      chk("t4_rst_last", rd_last, 0);

      // arm with abort in the same cycle: stays idle, nothing queued
      arm = 1'b1; abort = 1'b1; trigger_position = 4'd3;
      step();
      arm = 1'b0; abort = 1'b0;
      chk("t5_arm_abort_busy", busy, 0);
      chk("t5_arm_abort_wr_en", wr_en, 0);
      step();
      chk("t5_no_queue", busy, 0);

      // abort during READ
      arm = 1'b1; trigger_position = 4'd15;
      step();
      arm = 1'b0;
      steps(15);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      chk("t6_done", capture_done, 1);
      chk("t6_rd_base", rd_addr, 0);
      chk("t6_trig_addr", trig_addr, 15);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6_valid_drop", rd_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_done_low", capture_done, 0);
      chk("t6_last_low", rd_last, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
